// File: rtl/dist_pkg.sv
// Shared constants, sqrt engine state encoding and a clog2 helper for the
// distance datapath (also used by dist_control_unit).
package dist_pkg;

  localparam int DEF_VARWIDTH = 32;
  localparam int DEF_LOGVEC   = 8;
  localparam int DEF_ACCWIDTH = 2*DEF_VARWIDTH + DEF_LOGVEC;
  localparam int DEF_OUTWIDTH = DEF_ACCWIDTH/2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Iterative restoring integer square root: one result bit per cycle,
// two radicand bits consumed per step, MSB first.
module isqrt_seq
  import dist_pkg::*;
#(
  parameter int W  = DEF_ACCWIDTH,
  parameter int OW = W/2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  radicand,
  output logic [OW-1:0] root_out,
  output logic          done
);

  localparam int CW = (clog2(OW) < 1) ? 1 : clog2(OW);

  sqrt_state_e   state;
  logic [W-1:0]  rad;
  logic [OW+1:0] rem;
  logic [OW-1:0] root;
  logic [CW-1:0] cnt;

  logic [OW+1:0] rem_sh, trial, rem_nxt;
  logic [OW-1:0] root_nxt;
  logic          fits;

  // Remainder stays below 2^OW before each shift, so OW+2 bits hold the shifted value.
  always_comb begin
    rem_sh   = (rem << 2) | (OW+2)'(rad[W-1:W-2]);
    trial    = {root, 2'b01};
    fits     = (rem_sh >= trial);
    rem_nxt  = fits ? (rem_sh - trial) : rem_sh;
    root_nxt = {root[OW-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      root_out <= '0;
      done     <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      root_out <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rad   <= radicand;
            rem   <= '0;
            root  <= '0;
            cnt   <= CW'(OW-1);
            done  <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          rad  <= rad << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            root_out <= root_nxt;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dist_acc_sqrt.sv
// Saturating sum-of-squares accumulator feeding a sequential square root;
// answers the Acc/Sqrt handshake of dist_control_unit.
module dist_acc_sqrt
  import dist_pkg::*;
#(
  parameter int VARWIDTH = DEF_VARWIDTH,
  parameter int LOGVEC   = DEF_LOGVEC,
  parameter int ACCWIDTH = 2*VARWIDTH + LOGVEC,
  parameter int OUTWIDTH = ACCWIDTH/2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EN_Acc,
  input  logic                  RST_Acc,
  input  logic                  PRE_Acc,
  input  logic [2*VARWIDTH-1:0] in_sq,
  input  logic                  EN_Sqrt,
  input  logic                  RST_Sqrt,
  output logic                  RDY_Acc,
  output logic                  RDY_Sqrt,
  output logic [ACCWIDTH-1:0]   acc_out,
  output logic                  acc_ovf,
  output logic [OUTWIDTH-1:0]   outval
);

  localparam int PADW = ACCWIDTH - 2*VARWIDTH;

  logic [ACCWIDTH-1:0] acc;
  logic [ACCWIDTH:0]   sum;

  assign sum     = {1'b0, acc} + {{(PADW+1){1'b0}}, in_sq};
  assign acc_out = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      RDY_Acc <= 1'b0;
    end else if (RST_Acc) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      RDY_Acc <= 1'b0;
    end else if (PRE_Acc) begin
      acc     <= {{PADW{1'b0}}, in_sq};
      acc_ovf <= 1'b0;
      RDY_Acc <= 1'b1;
    end else if (EN_Acc) begin
      // Carry out pins the sum at full scale; the flag stays until the next clear/preset.
      acc     <= sum[ACCWIDTH] ? '1 : sum[ACCWIDTH-1:0];
      if (sum[ACCWIDTH]) acc_ovf <= 1'b1;
      RDY_Acc <= 1'b1;
    end
  end

  isqrt_seq #(.W(ACCWIDTH), .OW(OUTWIDTH)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (EN_Sqrt),
    .abort    (RST_Sqrt),
    .radicand (acc),
    .root_out (outval),
    .done     (RDY_Sqrt)
  );

endmodule

// File: tb/tb_dist_acc_sqrt.sv
// Self-checking bench for dist_acc_sqrt: root table plus handshake corner sequences.
module tb_dist_acc_sqrt;

  localparam int AW  = 72;
  localparam int OW  = 36;
  localparam int LAT = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          EN_Acc = 1'b0, RST_Acc = 1'b0, PRE_Acc = 1'b0;
  logic [63:0]   in_sq = '0;
  logic          EN_Sqrt = 1'b0, RST_Sqrt = 1'b0;
  logic          RDY_Acc, RDY_Sqrt, acc_ovf;
  logic [AW-1:0] acc_out;
  logic [OW-1:0] outval;

  dist_acc_sqrt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .EN_Acc   (EN_Acc),
    .RST_Acc  (RST_Acc),
    .PRE_Acc  (PRE_Acc),
    .in_sq    (in_sq),
    .EN_Sqrt  (EN_Sqrt),
    .RST_Sqrt (RST_Sqrt),
    .RDY_Acc  (RDY_Acc),
    .RDY_Sqrt (RDY_Sqrt),
    .acc_out  (acc_out),
    .acc_ovf  (acc_ovf),
    .outval   (outval)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]   rad;
    logic [OW-1:0] root;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [OW-1:0] sb[$];
  vec_t          tbl[11];

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc_op(input logic rst, input logic pre, input logic en, input logic [63:0] v);
    RST_Acc = rst; PRE_Acc = pre; EN_Acc = en; in_sq = v;
    tick();
    RST_Acc = 1'b0; PRE_Acc = 1'b0; EN_Acc = 1'b0;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!RDY_Sqrt && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic sb_check(input string nm, input int n);
    logic [OW-1:0] exp;
    chk({nm, " latency"}, AW'(n), AW'(LAT));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got output with empty scoreboard", nm);
    end else begin
      exp = sb.pop_front();
      chk(nm, AW'(outval), AW'(exp));
    end
  endtask

  task automatic do_sqrt(input string nm, input logic [OW-1:0] exp);
    int n;
    sb.push_back(exp);
    EN_Sqrt = 1'b1;
    tick();
    EN_Sqrt = 1'b0;
    wait_rdy(n);
    sb_check(nm, n);
  endtask

  initial begin
    int n;
    tbl = '{
      '{64'd0,                   36'd0},
      '{64'd1,                   36'd1},
      '{64'd26,                  36'd5},
      '{64'd2,                   36'd1},
      '{64'd4,                   36'd2},
      '{64'd99,                  36'd9},
      '{64'd100,                 36'd10},
      '{64'd1524157875019052100, 36'd1234567890},
      '{64'hFFFF_FFFF_FFFF_FFFF, 36'hFFFF_FFFF},
      '{64'hFFFF_FFFE_0000_0001, 36'hFFFF_FFFF},
      '{64'hFFFF_FFFE_0000_0000, 36'hFFFF_FFFE}
    };

    // reset state
    #12;
    chk("rst acc", acc_out, '0);
    chk("rst ovf", AW'(acc_ovf), '0);
    chk("rst rdy_acc", AW'(RDY_Acc), '0);
    chk("rst rdy_sqrt", AW'(RDY_Sqrt), '0);
    chk("rst outval", AW'(outval), '0);
    #1 rst_n = 1'b1;
    tick();

    // 9 + 16 -> 25 -> 5
    acc_op(0, 1, 0, 64'd9);
    acc_op(0, 0, 1, 64'd16);
    chk("acc 25", acc_out, AW'(25));
    chk("rdy_acc", AW'(RDY_Acc), AW'(1));
    do_sqrt("root 25", 36'd5);

    for (int i = 0; i < 11; i++) begin
      acc_op(0, 1, 0, tbl[i].rad);
      chk($sformatf("tbl%0d acc", i), acc_out, AW'(tbl[i].rad));
      do_sqrt($sformatf("tbl%0d root", i), tbl[i].root);
    end

    // saturation
    acc_op(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 300; i++) acc_op(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sat acc", acc_out, {AW{1'b1}});
    chk("sat ovf", AW'(acc_ovf), AW'(1));
    acc_op(0, 0, 1, 64'd0);
    chk("ovf sticky", AW'(acc_ovf), AW'(1));
    do_sqrt("sat root", {OW{1'b1}});
    acc_op(1, 1, 1, 64'd5);
    chk("rst_acc acc", acc_out, '0);
    chk("rst_acc ovf", AW'(acc_ovf), '0);
    chk("rst_acc rdy", AW'(RDY_Acc), '0);

    // EN_Sqrt during CALC is ignored; acc changes underneath
    acc_op(0, 1, 0, 64'd25);
    sb.push_back(36'd5);
    EN_Sqrt = 1'b1;
    tick();
    EN_Sqrt = 1'b0;
    n = 0;
    while (!RDY_Sqrt && n < 100) begin
      if (n == 9) begin
        PRE_Acc = 1'b1; in_sq = 64'd100; EN_Sqrt = 1'b1;
      end
      tick();
      PRE_Acc = 1'b0; EN_Sqrt = 1'b0;
      n++;
    end
    sb_check("ignore root", n);
    chk("ignore acc", acc_out, AW'(100));
    RST_Sqrt = 1'b1;
    tick();
    RST_Sqrt = 1'b0;
    chk("abort rdy", AW'(RDY_Sqrt), '0);
    chk("abort outval", AW'(outval), '0);

    // RST_Sqrt beats a same-edge EN_Sqrt
    RST_Sqrt = 1'b1; EN_Sqrt = 1'b1;
    tick();
    RST_Sqrt = 1'b0; EN_Sqrt = 1'b0;
    repeat (40) tick();
    chk("abort prio rdy", AW'(RDY_Sqrt), '0);

    // same-edge capture sees the pre-update accumulator
    acc_op(0, 1, 0, 64'd25);
    sb.push_back(36'd5);
    EN_Sqrt = 1'b1; EN_Acc = 1'b1; in_sq = 64'd11;
    tick();
    EN_Sqrt = 1'b0; EN_Acc = 1'b0;
    chk("same edge acc", acc_out, AW'(36));
    wait_rdy(n);
    sb_check("same edge root", n);

    // async reset mid-calculation
    acc_op(0, 1, 0, 64'd100);
    EN_Sqrt = 1'b1;
    tick();
    EN_Sqrt = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async acc", acc_out, '0);
    chk("async ovf", AW'(acc_ovf), '0);
    chk("async rdy_acc", AW'(RDY_Acc), '0);
    chk("async rdy_sqrt", AW'(RDY_Sqrt), '0);
    chk("async outval", AW'(outval), '0);
    #2 rst_n = 1'b1;
    tick();
    acc_op(0, 1, 0, 64'd49);
    do_sqrt("post reset root", 36'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dist_acc_sqrt.md
Name: dist_acc_sqrt

Overview:
- Responder side of the distance control handshake: takes the Acc/Sqrt enables, resets and preset that dist_control_unit drives, and returns the RDY_Acc/RDY_Sqrt flags it waits on.
- Accumulates per-element squared differences from the subtract/square pipe, then computes the integer square root of the sum with an iterative engine.
- Output is the Euclidean distance of one vector pair.

Parameters:
- VARWIDTH, 32, width of one vector element; in_sq is 2*VARWIDTH wide.
- LOGVEC, 8, log2 of the maximum number of accumulated terms (256).
- ACCWIDTH, 2*VARWIDTH+LOGVEC (72), accumulator width. Must be even.
- OUTWIDTH, ACCWIDTH/2 (36), square-root result width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- EN_Acc  in  1  add in_sq to accumulator this cycle.
- RST_Acc  in  1  synchronous clear of accumulator.
- PRE_Acc  in  1  load accumulator with in_sq (first term).
- in_sq  in  2*VARWIDTH  squared difference from pipe.
- EN_Sqrt  in  1  start square root of current accumulator.
- RST_Sqrt  in  1  synchronous abort/clear of sqrt engine.
- RDY_Acc  out  1  accumulator holds the settled result of the previous op.
- RDY_Sqrt  out  1  outval valid.
- acc_out  out  ACCWIDTH  accumulator value.
- acc_ovf  out  1  sticky saturation flag.
- outval  out  OUTWIDTH  floor(sqrt(captured accumulator)).

Behaviour:
- Async reset (rst_n=0):
  - acc=0, acc_ovf=0, RDY_Acc=0, RDY_Sqrt=0, outval=0, engine state IDLE, all internal regs 0.
  - Takes effect immediately, mid-operation included. Recovery occurs on the first clk edge with rst_n=1.
- Accumulator, per-edge priority RST_Acc > PRE_Acc > EN_Acc:
  - RST_Acc: acc<=0, acc_ovf<=0, RDY_Acc<=0.
  - PRE_Acc: acc<=zero-extended in_sq, acc_ovf<=0, RDY_Acc<=1.
  - EN_Acc: acc<=acc+in_sq. On carry out of ACCWIDTH, acc saturates to all-ones and acc_ovf<=1 (sticky until RST_Acc/PRE_Acc). RDY_Acc<=1.
  - No control asserted: acc holds and RDY_Acc holds.
  - Latency is 1 cycle: the result is visible on acc_out the cycle after the enable.
- Sqrt engine FSM:
  - IDLE: on EN_Sqrt (and not RST_Sqrt), capture acc (the registered value, before any same-edge Acc update), clear the root/remainder regs, RDY_Sqrt<=0, go to CALC.
  - CALC: one restoring digit step per cycle, 2 radicand bits per step, MSB first, OUTWIDTH steps, counter from OUTWIDTH-1 down to 0. On the last step, outval<=root, RDY_Sqrt<=1, go to DONE.
  - DONE: outval and RDY_Sqrt held. EN_Sqrt starts a new calculation exactly as from IDLE, and RDY_Sqrt drops the next cycle.
  - RST_Sqrt in any state: outval<=0, RDY_Sqrt<=0, go to IDLE. RST_Sqrt has priority over a same-cycle EN_Sqrt.
  - EN_Sqrt during CALC is ignored: no restart, no error.
  - Latency: EN_Sqrt sampled at edge T gives RDY_Sqrt=1 and valid outval after edge T+OUTWIDTH (36 cycles with defaults).
- Arithmetic:
  - Each step uses an unsigned remainder of OUTWIDTH+2 bits and a trial value of (root<<2)|1. If the trial fits, subtract it and shift in a 1; otherwise shift in a 0.
  - Result is an exact floor for all inputs 0..2^ACCWIDTH-1.
- Acc ops during CALC are legal and do not disturb the captured radicand.

Decomposition:
- Package dist_pkg holds:
  - the sqrt state encoding (IDLE, CALC, DONE);
  - default width constants: VARWIDTH, LOGVEC, derived ACCWIDTH/OUTWIDTH;
  - a clog2 function shared with dist_control_unit.
- One sub-module, isqrt_seq: the iterative root engine (capture, step counter, FSM, remainder/root regs) with start/abort/done ports.
- The accumulator stays in the top level.

Test Plan:
- PRE_Acc with in_sq=9, then EN_Acc with in_sq=16 -> acc_out=25, RDY_Acc=1. EN_Sqrt -> RDY_Sqrt=1 exactly 36 cycles later, outval=5.
- Radicands 0, 1, 26, 2^72-1 -> outval 0, 1, 5, 2^36-1 respectively.
- PRE_Acc with in_sq=2^64-1, then 300 EN_Acc of 2^64-1 -> acc saturates at 2^72-1, acc_ovf=1. RST_Acc clears acc and acc_ovf to 0.
- EN_Sqrt on 25; at cycle 10, EN_Sqrt again with acc=100 -> ignored, outval=5 at cycle 36. RST_Sqrt in DONE -> outval=0, RDY_Sqrt=0 the next cycle.
- Same-edge EN_Sqrt and EN_Acc(in_sq=11) with acc=25 -> outval=5 (pre-update capture), acc_out=36.
- rst_n pulled low mid-CALC, between edges -> all outputs 0 immediately. After release, a fresh PRE_Acc 49 then EN_Sqrt -> outval=7.
